// File: rtl/mano_timing_decoder_pkg.sv
// Shared constants for the Mano basic-computer control unit: default widths,
// decoder output counts and named opcode strobe indices.
package mano_pkg;

  localparam int unsigned SC_W_DEFAULT = 4;
  localparam int unsigned OP_W_DEFAULT = 3;

  localparam int unsigned T_N = 2 ** SC_W_DEFAULT;
  localparam int unsigned D_N = 2 ** OP_W_DEFAULT;

  // Bit positions of d_o for the memory-reference and I/O instruction groups.
  localparam int unsigned D_AND = 0;
  localparam int unsigned D_ADD = 1;
  localparam int unsigned D_LDA = 2;
  localparam int unsigned D_STA = 3;
  localparam int unsigned D_BUN = 4;
  localparam int unsigned D_BSA = 5;
  localparam int unsigned D_ISZ = 6;
  localparam int unsigned D_IO  = 7;

endpackage

// File: rtl/mano_timing_decoder_onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable; output is all-zero when
// en is low, otherwise exactly one bit is set.
module onehot_decoder #(
  parameter int unsigned IN_W = 3
) (
  input  logic [IN_W-1:0]      in,
  input  logic                 en,
  output logic [2**IN_W-1:0]   out
);

  always_comb begin
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/mano_timing_decoder.sv
// Sequence counter with one-hot timing decode and latched one-hot opcode
// strobes for the Mano basic computer control unit.
module mano_timing_decoder
  import mano_pkg::*;
#(
  parameter int unsigned SC_W = SC_W_DEFAULT,
  parameter int unsigned OP_W = OP_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sc_clr,
  input  logic                 sc_inc,
  input  logic                 op_load,
  input  logic [OP_W-1:0]      op_in,
  output logic [SC_W-1:0]      sc_q,
  output logic [2**SC_W-1:0]   t_o,
  output logic [2**OP_W-1:0]   d_o,
  output logic                 d_valid,
  output logic                 t_wrap
);

  logic [SC_W-1:0] sc_d;
  logic            wrap_d;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] op_d;
  logic            d_valid_d;

  // Clear beats increment; a clear never counts as a wrap.
  always_comb begin
    sc_d   = sc_q;
    wrap_d = 1'b0;
    if (sc_clr) begin
      sc_d = '0;
    end else if (sc_inc) begin
      sc_d   = sc_q + SC_W'(1);
      wrap_d = (sc_q == '1);
    end
  end

  // A fresh load wins over the end-of-instruction clear.
  always_comb begin
    op_d      = op_q;
    d_valid_d = d_valid;
    if (op_load) begin
      op_d      = op_in;
      d_valid_d = 1'b1;
    end else if (sc_clr) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q    <= '0;
      t_wrap  <= 1'b0;
      op_q    <= '0;
      d_valid <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      t_wrap  <= wrap_d;
      op_q    <= op_d;
      d_valid <= d_valid_d;
    end
  end

  onehot_decoder #(
    .IN_W (SC_W)
  ) u_t_dec (
    .in  (sc_q),
    .en  (1'b1),
    .out (t_o)
  );

  onehot_decoder #(
    .IN_W (OP_W)
  ) u_d_dec (
    .in  (op_q),
    .en  (d_valid),
    .out (d_o)
  );

endmodule

// File: tb/tb_mano_timing_decoder.sv
// Directed bench for mano_timing_decoder at default widths and at SC_W=2/OP_W=2,
// with a reference model feeding an expected-result queue.
module tb_mano_timing_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        clr0, inc0, ld0;
  logic [2:0]  op0;
  logic [3:0]  sc0;
  logic [15:0] t0;
  logic [7:0]  d0;
  logic        dv0, wr0;

  logic        clr1, inc1, ld1;
  logic [1:0]  op1;
  logic [1:0]  sc1;
  logic [3:0]  t1;
  logic [3:0]  d1;
  logic        dv1, wr1;

  mano_timing_decoder #(
    .SC_W (4),
    .OP_W (3)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .sc_clr  (clr0),
    .sc_inc  (inc0),
    .op_load (ld0),
    .op_in   (op0),
    .sc_q    (sc0),
    .t_o     (t0),
    .d_o     (d0),
    .d_valid (dv0),
    .t_wrap  (wr0)
  );

  mano_timing_decoder #(
    .SC_W (2),
    .OP_W (2)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .sc_clr  (clr1),
    .sc_inc  (inc1),
    .op_load (ld1),
    .op_in   (op1),
    .sc_q    (sc1),
    .t_o     (t1),
    .d_o     (d1),
    .d_valid (dv1),
    .t_wrap  (wr1)
  );

  typedef struct {
    int          inst;
    string       tag;
    logic [3:0]  sc;
    logic [15:0] t;
    logic [7:0]  d;
    logic        dv;
    logic        wrap;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  int   m_sc[2];
  int   m_op[2];
  logic m_dv[2];
  logic m_wrap[2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict next state, then compare after the edge.
  task automatic step(input int inst, input logic r, input logic c, input logic i,
                      input logic l, input logic [2:0] op, input string tag);
    exp_t e;
    int   w;
    int   ow;
    int   mx;
    logic [15:0] o_sc, o_t, o_d, o_dv, o_wr;
    w  = (inst == 0) ? 4 : 2;
    ow = (inst == 0) ? 3 : 2;
    mx = (1 << w) - 1;
    rst = r;
    if (inst == 0) begin
      clr0 = c; inc0 = i; ld0 = l;
      op0  = l ? op : 3'bx;
    end else begin
      clr1 = c; inc1 = i; ld1 = l;
      op1  = l ? op[1:0] : 2'bx;
    end
    if (r) begin
      m_sc[inst] = 0; m_op[inst] = 0; m_dv[inst] = 1'b0; m_wrap[inst] = 1'b0;
    end else begin
      m_wrap[inst] = !c && i && (m_sc[inst] == mx);
      if (c) m_sc[inst] = 0;
      else if (i) m_sc[inst] = (m_sc[inst] + 1) & mx;
      if (l) begin
        m_op[inst] = int'(op) & ((1 << ow) - 1);
        m_dv[inst] = 1'b1;
      end else if (c) begin
        m_dv[inst] = 1'b0;
      end
    end
    e.inst = inst;
    e.tag  = tag;
    e.sc   = 4'(m_sc[inst]);
    e.t    = 16'(1) << m_sc[inst];
    e.d    = m_dv[inst] ? (8'(1) << m_op[inst]) : 8'h00;
    e.dv   = m_dv[inst];
    e.wrap = m_wrap[inst];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.inst == 0) begin
      o_sc = {12'h0, sc0}; o_t = t0; o_d = {8'h0, d0};
      o_dv = {15'h0, dv0}; o_wr = {15'h0, wr0};
    end else begin
      o_sc = {14'h0, sc1}; o_t = {12'h0, t1}; o_d = {12'h0, d1};
      o_dv = {15'h0, dv1}; o_wr = {15'h0, wr1};
    end
    check({e.tag, ".sc_q"},    o_sc, {12'h0, e.sc});
    check({e.tag, ".t_o"},     o_t,  e.t);
    check({e.tag, ".d_o"},     o_d,  {8'h0, e.d});
    check({e.tag, ".d_valid"}, o_dv, {15'h0, e.dv});
    check({e.tag, ".t_wrap"},  o_wr, {15'h0, e.wrap});
  endtask

  initial begin
    rst  = 1'b1;
    clr0 = 1'b0; inc0 = 1'b0; ld0 = 1'b0; op0 = 3'b0;
    clr1 = 1'b0; inc1 = 1'b0; ld1 = 1'b0; op1 = 2'b0;

    // Default widths: reset and idle stability.
    step(0, 1, 0, 0, 0, 3'd0, "w4.reset");
    step(0, 1, 0, 0, 0, 3'd0, "w4.reset");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 3'd0, "w4.idle");
    check("w4.t_o_reset_const", t0, 16'h0001);

    // Count through all 16 states and wrap.
    for (int k = 0; k < 16; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.count");
    check("w4.wrap_pulse_const", {15'h0, wr0}, 16'h0001);
    step(0, 0, 0, 0, 0, 3'd0, "w4.after_wrap");

    // Clear beats increment at sc_q=5.
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.to5");
    step(0, 0, 1, 1, 0, 3'd0, "w4.clr_vs_inc");

    // Opcode load at T2, hold while counting, then end-of-instruction clear.
    for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.to2");
    step(0, 0, 0, 0, 1, 3'b011, "w4.load_sta");
    check("w4.d_o_sta_const", {8'h0, d0}, 16'h0008);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.hold_op");
    step(0, 0, 1, 0, 0, 3'd0, "w4.clr_op");

    // Load and clear together.
    step(0, 0, 1, 0, 1, 3'b000, "w4.load_vs_clr");
    check("w4.d_o_and_const", {8'h0, d0}, 16'h0001);

    // Counter clear at max must not flag a wrap.
    for (int k = 0; k < 15; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.to15");
    step(0, 0, 1, 1, 0, 3'd0, "w4.clr_at_max");

    // Reset mid-operation overrides increment and load.
    for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 0, 3'd0, "w4.to9");
    step(0, 0, 0, 0, 1, 3'b110, "w4.load_isz");
    step(0, 1, 0, 1, 1, 3'b101, "w4.mid_reset");

    // Narrow instance: reset, count/wrap, clear priority, opcode load.
    step(1, 1, 0, 0, 0, 3'd0, "w2.reset");
    step(1, 1, 0, 0, 0, 3'd0, "w2.reset");
    for (int k = 0; k < 2; k++) step(1, 0, 0, 0, 0, 3'd0, "w2.idle");
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0, 3'd0, "w2.count");
    step(1, 0, 0, 0, 0, 3'd0, "w2.after_wrap");
    for (int k = 0; k < 2; k++) step(1, 0, 0, 1, 0, 3'd0, "w2.to2");
    step(1, 0, 1, 1, 0, 3'd0, "w2.clr_vs_inc");
    step(1, 0, 0, 1, 1, 3'b011, "w2.load3");
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 3'd0, "w2.hold_op");
    step(1, 0, 1, 0, 0, 3'd0, "w2.clr_op");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
